// File: rtl/led_pkg.sv
// Shared LED levels and breathing-ramp direction type for led_blink.
package led_pkg;

    localparam logic LED_OFF = 1'b0;
    localparam logic LED_ON  = 1'b1;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/led_blink_if.sv
// LED pin bundle: the driver owns the pin, the board/observer samples it.
interface led_blink_if;

    logic led;

    modport master (output led);
    modport slave  (input  led);

endinterface

// File: rtl/led_tick_gen.sv
// Free-running 0..DIV-1 counter; tick is high for the single cycle where cnt wraps.
module led_tick_gen #(
    parameter int unsigned DIV = 10,
    localparam int unsigned W  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] cnt,
    output logic         tick
);

    localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_blink.sv
// Board LED driver: square-wave blink by default, PWM breathing ramp when
// LED_BREATH_EN is defined.
module led_blink
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned HALF_PERIOD_CYC = 25_000_000,
    parameter logic        LED_ON_LEVEL    = 1'b1,
    parameter int unsigned PWM_STEPS       = 1000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    led_blink_if.master     led_if
);

    if (CLK_FREQ_HZ == 0 || HALF_PERIOD_CYC < 2 || PWM_STEPS < 2) begin : g_param_check
        $error("led_blink: CLK_FREQ_HZ must be nonzero, HALF_PERIOD_CYC and PWM_STEPS >= 2");
    end

    logic led_q;

    assign led_if.led = led_q;

`ifndef LED_BREATH_EN

    localparam int unsigned BW = $clog2(HALF_PERIOD_CYC);

    logic [BW-1:0] unused_blink_cnt;
    logic          blink_tick;
    logic          state;
    logic          state_next;

    led_tick_gen #(
        .DIV (HALF_PERIOD_CYC)
    ) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .cnt   (unused_blink_cnt),
        .tick  (blink_tick)
    );

    assign state_next = blink_tick ? ~state : state;

    // The pin flop follows state_next so led changes on the same edge as state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= LED_OFF;
            led_q <= ~LED_ON_LEVEL;
        end else begin
            state <= state_next;
            led_q <= (state_next == LED_ON) ? LED_ON_LEVEL : ~LED_ON_LEVEL;
        end
    end

`else

    localparam int unsigned PW = $clog2(PWM_STEPS);
    localparam int unsigned DW = $clog2(PWM_STEPS + 1);
    localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_STEPS);

    logic [PW-1:0] pwm_cnt;
    logic          frame_end;
    logic [DW-1:0] duty;
    dir_t          dir;
    logic          lit;

    led_tick_gen #(
        .DIV (PWM_STEPS)
    ) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .cnt   (pwm_cnt),
        .tick  (frame_end)
    );

    assign lit = (DW'(pwm_cnt) < duty);

    // Direction flips on the step away from an end point, so both 0 and
    // PWM_STEPS each get exactly one frame per breath.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            duty  <= '0;
            dir   <= DIR_UP;
            led_q <= ~LED_ON_LEVEL;
        end else begin
            led_q <= lit ? LED_ON_LEVEL : ~LED_ON_LEVEL;
            if (frame_end) begin
                if (dir == DIR_UP) begin
                    if (duty == DUTY_MAX) begin
                        duty <= duty - 1'b1;
                        dir  <= DIR_DOWN;
                    end else begin
                        duty <= duty + 1'b1;
                    end
                end else begin
                    if (duty == '0) begin
                        duty <= duty + 1'b1;
                        dir  <= DIR_UP;
                    end else begin
                        duty <= duty - 1'b1;
                    end
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_led_blink.sv
// Directed bench for led_blink: an active-high and an active-low instance share clock and reset.
module tb_led_blink;

    localparam int unsigned HALF  = 10;
    localparam int unsigned STEPS = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #10 sys_clk = ~sys_clk;

    led_blink_if if_hi ();
    led_blink_if if_lo ();

    led_blink #(
        .HALF_PERIOD_CYC (HALF),
        .LED_ON_LEVEL    (1'b1),
        .PWM_STEPS       (STEPS)
    ) u_dut_hi (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_if    (if_hi)
    );

    led_blink #(
        .HALF_PERIOD_CYC (HALF),
        .LED_ON_LEVEL    (1'b0),
        .PWM_STEPS       (STEPS)
    ) u_dut_lo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_if    (if_lo)
    );

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // lit: whether the LED should be glowing; each instance maps that to its own pin level.
    task automatic check_pair(input string name, input logic lit);
        check_bit({name, "_hi"}, if_hi.led, lit);
        check_bit({name, "_lo"}, if_lo.led, ~lit);
    endtask

    typedef struct {
        logic        rst_n;
        int unsigned cycles;
        logic        lit;
        string       name;
    } vec_t;

    task automatic run_frame(output int unsigned hi_lit, output int unsigned lo_lit);
        hi_lit = 0;
        lo_lit = 0;
        repeat (STEPS) begin
            @(negedge sys_clk);
            #1;
            if (if_hi.led === 1'b1) hi_lit++;
            if (if_lo.led === 1'b0) lo_lit++;
        end
    endtask

    initial begin
        int unsigned hi_lit;
        int unsigned lo_lit;
        vec_t vecs[$];

        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            #1;
            check_pair($sformatf("rst_hold%0d", i), 1'b0);
        end
        sys_rst_n = 1'b1;

`ifndef LED_BREATH_EN
        hi_lit = 0;
        for (int unsigned k = 1; k <= 100; k++) begin
            @(negedge sys_clk);
            #1;
            check_pair($sformatf("blink_k%0d", k), ((k / HALF) % 2) == 1);
            if (if_hi.led === 1'b1) hi_lit++;
        end
        check_int("duty50", hi_lit, 50);

        vecs.push_back('{1'b1, 10, 1'b1, "rise_k110"});
        vecs.push_back('{1'b1,  3, 1'b1, "toggle_plus3"});
        vecs.push_back('{1'b0,  0, 1'b0, "async_rst"});
        vecs.push_back('{1'b0,  5, 1'b0, "rst_held"});
        vecs.push_back('{1'b1,  9, 1'b0, "rel_edge9"});
        vecs.push_back('{1'b1,  1, 1'b1, "rel_edge10"});
        vecs.push_back('{1'b1,  9, 1'b1, "rel_edge19"});
        vecs.push_back('{1'b1,  1, 1'b0, "rel_edge20"});
        vecs.push_back('{1'b1, 10, 1'b1, "rel_edge30"});

        foreach (vecs[i]) begin
            sys_rst_n = vecs[i].rst_n;
            if (vecs[i].cycles == 0) begin
                #1;
            end else begin
                repeat (vecs[i].cycles) @(negedge sys_clk);
                #1;
            end
            check_pair(vecs[i].name, vecs[i].lit);
        end
`else
        begin
            int unsigned exp_hi[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
            for (int f = 0; f < 10; f++) begin
                run_frame(hi_lit, lo_lit);
                check_int($sformatf("frame%0d_hi", f), hi_lit, exp_hi[f]);
                check_int($sformatf("frame%0d_lo", f), lo_lit, exp_hi[f]);
            end
        end

        sys_rst_n = 1'b0;
        #1;
        check_pair("rst_again", 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) run_frame(hi_lit, lo_lit);
        repeat (2) @(negedge sys_clk);
        #1;
        check_pair("mid_duty3_down", 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check_pair("rst_mid_ramp", 1'b0);
        repeat (3) @(negedge sys_clk);
        #1;
        check_pair("rst_mid_held", 1'b0);
        sys_rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(hi_lit, lo_lit);
            check_int($sformatf("restart%0d_hi", f), hi_lit, f);
            check_int($sformatf("restart%0d_lo", f), lo_lit, f);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
